steer_enable_ctrl: RTL and testbench

Parametrised rider-detect and steering-enable controller for the balance platform. It watches the left and right load-cell readings and asserts `en_steer` once a rider has stood balanced for a programmable settle time. It declares `rider_off` after a debounced, hysteretic weight loss. It sits between the A2D load-cell path and the steering/PID block, and generalises the fixed-threshold steering enable with hysteresis, off-debounce, configurable balance fractions and a state status port.

---
 rtl/steer_enable_ctrl.sv | 120 ++++++++++++
 tb/tb_steer_enable_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/steer_enable_ctrl.sv
// Rider-detect and steering-enable controller: settles a balanced rider before enabling
// steering, and debounces weight loss with hysteresis before declaring the rider off.
module steer_enable_ctrl #(
   parameter int unsigned     LD_W         = 12,
   parameter logic [LD_W-1:0] MIN_RIDER_WT = 12'h200,
   parameter logic [LD_W-1:0] HYST         = 12'h040,
   parameter int unsigned     SETTLE_BITS  = 26,
   parameter bit              fast_sim     = 1'b0,
   parameter int unsigned     OFF_DEB      = 4,
   parameter int unsigned     ENTER_SHIFT  = 2,
   parameter int unsigned     EXIT_SHIFT   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [LD_W-1:0] lft_ld,
   input  logic [LD_W-1:0] rght_ld,
   output logic            en_steer,
   output logic            rider_off,
   output logic [1:0]      steer_state
);

   localparam int unsigned TW  = fast_sim ? 15 : SETTLE_BITS;
   localparam int unsigned OCW = ($clog2(OFF_DEB) > 0) ? $clog2(OFF_DEB) : 1;
   localparam logic [OCW-1:0] OFF_LAST = OCW'(OFF_DEB - 1);
   localparam logic [LD_W:0]  ON_THR   = {1'b0, MIN_RIDER_WT};
   localparam logic [LD_W:0]  OFF_THR  = {1'b0, MIN_RIDER_WT - HYST};

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StSteer = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [OCW-1:0]  off_cnt_q, off_cnt_d;
   logic            rider_off_q, rider_off_d;
   logic            en_steer_q;

   logic [LD_W:0]   sum;
   logic [LD_W-1:0] diff;
   logic            low;
   logic            balanced;
   logic            exit_unbal;
   logic            off_evt;

   always_comb begin
      sum        = {1'b0, lft_ld} + {1'b0, rght_ld};
      diff       = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
      low        = sum < OFF_THR;
      balanced   = {1'b0, diff} < (sum >> ENTER_SHIFT);
      exit_unbal = {1'b0, diff} > (sum - (sum >> EXIT_SHIFT));
      off_evt    = low && (off_cnt_q == OFF_LAST);
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      rider_off_d = rider_off_q;
      off_cnt_d   = '0;

      // off_evt leaves for IDLE, so the counter never needs to wrap past OFF_LAST
      if (state_q != StIdle && low && !off_evt) begin
         off_cnt_d = off_cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (sum > ON_THR) begin
               state_d     = StWait;
               timer_d     = '0;
               rider_off_d = 1'b0;
            end
         end
         StWait: begin
            if (off_evt) begin
               state_d     = StIdle;
               rider_off_d = 1'b1;
            end else if (!balanced) begin
               timer_d = '0;
            end else if (&timer_q) begin
               state_d = StSteer;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StSteer: begin
            if (off_evt) begin
               state_d     = StIdle;
               rider_off_d = 1'b1;
            end else if (exit_unbal) begin
               state_d = StWait;
               timer_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         off_cnt_q   <= '0;
         rider_off_q <= 1'b0;
         en_steer_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         off_cnt_q   <= off_cnt_d;
         rider_off_q <= rider_off_d;
         en_steer_q  <= (state_d == StSteer);
      end
   end

   assign en_steer    = en_steer_q;
   assign rider_off   = rider_off_q;
   assign steer_state = state_q;

endmodule

// File: tb/tb_steer_enable_ctrl.sv
// Directed bench for steer_enable_ctrl (fast_sim build): expected outputs are queued as each
// stimulus step is driven and compared once the DUT has had the required edges.
module tb_steer_enable_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] lft_ld;
   logic [11:0] rght_ld;
   logic        en_steer;
   logic        rider_off;
   logic [1:0]  steer_state;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic       ro;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   errors    = 0;
   int   ro_glitch = 0;
   logic ro_watch  = 1'b0;

   steer_enable_ctrl #(
      .LD_W        (12),
      .MIN_RIDER_WT(12'h200),
      .HYST        (12'h040),
      .SETTLE_BITS (26),
      .fast_sim    (1'b1),
      .OFF_DEB     (4),
      .ENTER_SHIFT (2),
      .EXIT_SHIFT  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lft_ld     (lft_ld),
      .rght_ld    (rght_ld),
      .en_steer   (en_steer),
      .rider_off  (rider_off),
      .steer_state(steer_state)
   );

   always #5 clk = ~clk;

   // rider_off must stay low through the whole first settle / steer / exit sequence
   always @(negedge clk) begin
      if (ro_watch && rider_off) ro_glitch++;
   end

   task automatic drive(input logic [11:0] l, input logic [11:0] r);
      lft_ld  = l;
      rght_ld = r;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input string tag, input logic [1:0] st, input logic ro);
      exp_t e;
      e.tag = tag;
      e.st  = st;
      e.ro  = ro;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t       e;
      logic [3:0] obs;
      logic [3:0] exp_v;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty: observed no entry, expected one");
         return;
      end
      e     = sb.pop_front();
      exp_v = {e.st, (e.st == 2'd2), e.ro};
      obs   = {steer_state, en_steer, rider_off};
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed state=%0d en_steer=%b rider_off=%b, expected state=%0d en_steer=%b rider_off=%b",
                e.tag, obs[3:2], obs[1], obs[0], exp_v[3:2], exp_v[1], exp_v[0]);
      end
   endtask

   // Queue the expectation for the step just driven, advance n edges, then compare.
   task automatic run(input int n, input string tag, input logic [1:0] st, input logic ro);
      expect_st(tag, st, ro);
      tick(n);
      check_out();
   endtask

   initial begin
      rst_n = 1'b0;
      drive(12'h000, 12'h000);
      #2;
      expect_st("reset_state", 2'd0, 1'b0);
      check_out();
      #10 rst_n = 1'b1;
      tick(1);

      // IDLE boundaries: sum below and exactly at the rider-on threshold
      drive(12'h0A8, 12'h100);
      run(100, "idle_below_on", 2'd0, 1'b0);
      drive(12'h100, 12'h100);
      run(5, "idle_sum_eq_on", 2'd0, 1'b0);

      // Settle: WAIT next edge, STEER exactly 32768 edges later
      drive(12'h1A6, 12'h1A0);
      ro_watch = 1'b1;
      run(1, "idle_to_wait", 2'd1, 1'b0);
      run(32767, "wait_before_settle", 2'd1, 1'b0);
      run(1, "settle_to_steer", 2'd2, 1'b0);

      // Two 3-cycle dips separated by a restore must not accumulate
      drive(12'h012, 12'h003);
      run(3, "dip3_stays_steer", 2'd2, 1'b0);
      drive(12'h1A6, 12'h1A0);
      run(1, "dip_restore", 2'd2, 1'b0);
      drive(12'h012, 12'h003);
      run(3, "second_dip_steer", 2'd2, 1'b0);
      drive(12'h1A6, 12'h1A0);
      run(2, "dip2_restore", 2'd2, 1'b0);

      // Exit: equality does not exit, larger diff drops to WAIT in one edge
      drive(12'h1F0, 12'h010);
      run(1, "exit_boundary_no_exit", 2'd2, 1'b0);
      drive(12'h2A8, 12'h012);
      run(1, "unbalanced_exit", 2'd1, 1'b0);
      drive(12'h0F0, 12'h0F0);
      run(50, "hyst_band_wait", 2'd1, 1'b0);
      drive(12'h0E0, 12'h0E0);
      run(10, "off_threshold_not_low", 2'd1, 1'b0);

      // Mid-timer imbalance at diff == sum>>2 restarts the full settle count
      drive(12'h1A6, 12'h1A0);
      run(2000, "wait_mid_timer", 2'd1, 1'b0);
      drive(12'h140, 12'h0C0);
      run(1, "enter_boundary_unbal", 2'd1, 1'b0);
      drive(12'h1A6, 12'h1A0);
      run(32767, "restart_before_settle", 2'd1, 1'b0);
      run(1, "restart_settle_steer", 2'd2, 1'b0);

      ro_watch = 1'b0;
      checks++;
      assert (ro_glitch === 0) else begin
         errors++;
         $error("FAIL rider_off_glitches: observed %0d cycles high, expected 0", ro_glitch);
      end

      // Asynchronous reset mid-STEER, then settle starts over
      #3 rst_n = 1'b0;
      #1;
      expect_st("async_reset_steer", 2'd0, 1'b0);
      check_out();
      run(1, "held_in_reset", 2'd0, 1'b0);
      rst_n = 1'b1;
      run(1, "rearm_wait", 2'd1, 1'b0);
      run(1000, "no_early_steer", 2'd1, 1'b0);

      // Debounced weight loss from WAIT
      drive(12'h012, 12'h003);
      run(3, "low3_still_wait", 2'd1, 1'b0);
      run(1, "off_evt_idle", 2'd0, 1'b1);
      run(5, "idle_holds_rider_off", 2'd0, 1'b1);
      drive(12'h100, 12'h100);
      run(3, "idle_eq_on_keeps_off", 2'd0, 1'b1);
      drive(12'h1A6, 12'h1A0);
      run(1, "rider_on_clears_off", 2'd1, 1'b0);

      // One below the off threshold counts as low
      drive(12'h0E0, 12'h0DF);
      run(3, "below_off_thr_3", 2'd1, 1'b0);
      run(1, "below_off_thr_idle", 2'd0, 1'b1);

      // Asynchronous reset clears a held rider_off immediately
      #3 rst_n = 1'b0;
      #1;
      expect_st("async_reset_rider_off", 2'd0, 1'b0);
      check_out();
      #2 rst_n = 1'b1;
      drive(12'h000, 12'h000);
      run(3, "post_reset_idle", 2'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
